// File: rtl/imem_pkg.sv
// imem_pkg: shared widths and the owner encoding used by the instruction-memory
// arbiter and its round-robin grant generator.
package imem_pkg;

    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DATA_W = 32;

    // Which port owned the most recent granted access.
    typedef enum logic {
        OWN_FETCH  = 1'b0,
        OWN_LOADER = 1'b1
    } imem_owner_e;

endpackage : imem_pkg

// File: rtl/imem_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin grant generator. Grants are combinational
// from the requests and the registered last owner. On a conflict the port that
// did not win last time is granted.
module rr_arb2
    import imem_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic f_req,
    input  logic l_req,
    output logic f_gnt,
    output logic l_gnt
);

    imem_owner_e last_owner;

    // Grant selection; both grants are held low while in reset.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (reset_n) begin
            if (f_req && l_req) begin
                f_gnt = (last_owner == OWN_LOADER);
                l_gnt = (last_owner == OWN_FETCH);
            end else begin
                f_gnt = f_req;
                l_gnt = l_req;
            end
        end
    end

    // Remember the winner of each granted cycle; reset favours fetch on the first conflict.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignment so all flops update together at the edge.
        if (!reset_n) begin
            last_owner <= OWN_LOADER;
        end else if (f_gnt) begin
            last_owner <= OWN_FETCH;
        end else if (l_gnt) begin
            last_owner <= OWN_LOADER;
        end
    end

endmodule : rr_arb2

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port instruction blockram between the fetch
// port (read only) and the debug loader port (read/write). One access per cycle,
// round-robin on conflict, read data returned one cycle after the grant.
// Optional build macro: IMEM_ARB_STALL_CNT_EN adds the saturating f_stall_cnt output.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  f_req,
    input  logic [ADDR_W-1:0]     f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic [DATA_W-1:0]     f_rdata,
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic [ADDR_W-1:0]     l_addr,
    input  logic [DATA_W/8-1:0]   l_be,
    input  logic [DATA_W-1:0]     l_wdata,
    output logic                  l_gnt,
    output logic                  l_rvalid,
    output logic [DATA_W-1:0]     l_rdata,
    output logic [ADDR_W-1:0]     m_address,
    output logic [DATA_W/8-1:0]   m_byteenable,
    output logic                  m_chipselect,
    output logic                  m_write,
    output logic                  m_debugaccess,
    output logic [DATA_W-1:0]     m_writedata,
    output logic                  m_clken,
    output logic                  m_reset_req,
    input  logic [DATA_W-1:0]     m_readdata
`ifdef IMEM_ARB_STALL_CNT_EN
    ,
    output logic [31:0]           f_stall_cnt
`endif
);

    // Bit 0: fetch read issued last cycle; bit 1: loader read issued last cycle.
    logic [1:0] rd_owner;
    logic       l_wr_gnt;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .f_req   (f_req),
        .l_req   (l_req),
        .f_gnt   (f_gnt),
        .l_gnt   (l_gnt)
    );

    assign l_wr_gnt = l_gnt & l_we;

    // Memory side follows the granted port in the same cycle.
    always_comb begin
        m_chipselect  = f_gnt | l_gnt;
        m_address     = l_gnt ? l_addr : f_addr;
        m_byteenable  = l_wr_gnt ? l_be : '1;
        m_write       = l_wr_gnt;
        m_debugaccess = l_wr_gnt;
        m_writedata   = l_wdata;
        m_clken       = 1'b1;
        m_reset_req   = ~reset_n;
    end

    // Track which port owns the read data returning next cycle; writes return nothing.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_owner <= 2'b00;
        end else begin
            rd_owner <= {l_gnt & ~l_we, f_gnt};
        end
    end

    // Valids are masked by reset so an in-flight read is dropped as soon as reset asserts.
    assign f_rvalid = rd_owner[0] & reset_n;
    assign l_rvalid = rd_owner[1] & reset_n;
    assign f_rdata  = m_readdata;
    assign l_rdata  = m_readdata;

`ifdef IMEM_ARB_STALL_CNT_EN
    // Count cycles where fetch waits for the RAM, saturating at all ones.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            f_stall_cnt <= 32'd0;
        end else if (f_req && !f_gnt && (f_stall_cnt != 32'hFFFF_FFFF)) begin
            f_stall_cnt <= f_stall_cnt + 32'd1;
        end
    end
`endif

endmodule : imem_arbiter

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: self-checking bench for imem_arbiter with a behavioural
// blockram on the memory side, a directed vector table, hand-written corner
// sequences and a randomized phase checked against a reference model.
module tb_imem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt, f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          l_req, l_we;
    logic [AW-1:0] l_addr;
    logic [BW-1:0] l_be;
    logic [DW-1:0] l_wdata;
    logic          l_gnt, l_rvalid;
    logic [DW-1:0] l_rdata;
    logic [AW-1:0] m_address;
    logic [BW-1:0] m_byteenable;
    logic          m_chipselect, m_write, m_debugaccess, m_clken, m_reset_req;
    logic [DW-1:0] m_writedata;
    logic [DW-1:0] m_readdata = '0;
`ifdef IMEM_ARB_STALL_CNT_EN
    logic [31:0]   f_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .f_req         (f_req),
        .f_addr        (f_addr),
        .f_gnt         (f_gnt),
        .f_rvalid      (f_rvalid),
        .f_rdata       (f_rdata),
        .l_req         (l_req),
        .l_we          (l_we),
        .l_addr        (l_addr),
        .l_be          (l_be),
        .l_wdata       (l_wdata),
        .l_gnt         (l_gnt),
        .l_rvalid      (l_rvalid),
        .l_rdata       (l_rdata),
        .m_address     (m_address),
        .m_byteenable  (m_byteenable),
        .m_chipselect  (m_chipselect),
        .m_write       (m_write),
        .m_debugaccess (m_debugaccess),
        .m_writedata   (m_writedata),
        .m_clken       (m_clken),
        .m_reset_req   (m_reset_req),
        .m_readdata    (m_readdata)
`ifdef IMEM_ARB_STALL_CNT_EN
        ,
        .f_stall_cnt   (f_stall_cnt)
`endif
    );

    // Behavioural single-port blockram with byte enables and one-cycle read.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (m_chipselect) begin
            if (m_write) begin
                for (int b = 0; b < BW; b++)
                    if (m_byteenable[b]) ram[m_address][b*8 +: 8] <= m_writedata[b*8 +: 8];
            end
            m_readdata <= ram[m_address];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fr, input logic [AW-1:0] fa, input logic lr, input logic lw,
                         input logic [AW-1:0] la, input logic [BW-1:0] be, input logic [DW-1:0] wd);
        f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_addr = la; l_be = be; l_wdata = wd;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " f_gnt"}, f_gnt, 0);
        check({tag, " l_gnt"}, l_gnt, 0);
        check({tag, " f_rvalid"}, f_rvalid, 0);
        check({tag, " l_rvalid"}, l_rvalid, 0);
        check({tag, " m_chipselect"}, m_chipselect, 0);
        check({tag, " m_write"}, m_write, 0);
        check({tag, " m_debugaccess"}, m_debugaccess, 0);
        check({tag, " m_reset_req"}, m_reset_req, 1);
        check({tag, " m_clken"}, m_clken, 1);
`ifdef IMEM_ARB_STALL_CNT_EN
        check({tag, " f_stall_cnt"}, f_stall_cnt, 0);
`endif
    endtask

    // Two reset cycles with both ports requesting (grants must stay low), then release idle.
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        drive(1, 10'h1, 1, 0, 10'h2, 4'hF, 32'h0);
        @(negedge clk);
        check_reset_outputs(tag);
        tick();
        @(negedge clk);
        check_reset_outputs(tag);
        tick();
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic          fr;
        logic [AW-1:0] fa;
        logic          lr;
        logic          lw;
        logic [AW-1:0] la;
        logic [BW-1:0] be;
        logic [DW-1:0] wd;
        logic          e_fg;
        logic          e_lg;
        logic          e_frv;
        logic          e_lrv;
        logic [DW-1:0] e_rd;
    } vec_t;

    vec_t vecs [15];

    // Reference model state for the random phase.
    logic [DW-1:0] ref_mem [0:31];
    bit            prefer_fetch;

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = (i < 16) ? DW'(i * 4) : '0;

        // Directed sequence starting right after reset: fetch burst, loader write/read, conflicts.
        //           fr fa     lr lw la      be    wd             fg lg frv lrv rdata
        vecs[0]  = '{0, 10'd0, 0, 0, 10'd0,  4'h0, 32'h0,         0, 0, 0, 0, 32'h0};
        vecs[1]  = '{1, 10'd0, 0, 0, 10'd0,  4'h0, 32'h0,         1, 0, 0, 0, 32'h0};
        vecs[2]  = '{1, 10'd1, 0, 0, 10'd0,  4'h0, 32'h0,         1, 0, 1, 0, 32'd0};
        vecs[3]  = '{1, 10'd2, 0, 0, 10'd0,  4'h0, 32'h0,         1, 0, 1, 0, 32'd4};
        vecs[4]  = '{1, 10'd3, 0, 0, 10'd0,  4'h0, 32'h0,         1, 0, 1, 0, 32'd8};
        vecs[5]  = '{0, 10'd0, 1, 1, 10'h3FF, 4'h3, 32'hDEADBEEF, 0, 1, 1, 0, 32'd12};
        vecs[6]  = '{0, 10'd0, 1, 0, 10'h3FF, 4'h0, 32'h0,        0, 1, 0, 0, 32'h0};
        vecs[7]  = '{0, 10'd0, 0, 0, 10'd0,  4'h0, 32'h0,         0, 0, 0, 1, 32'h0000BEEF};
        vecs[8]  = '{1, 10'd5, 1, 0, 10'd6,  4'h0, 32'h0,         1, 0, 0, 0, 32'h0};
        vecs[9]  = '{1, 10'd7, 1, 0, 10'd6,  4'h0, 32'h0,         0, 1, 1, 0, 32'd20};
        vecs[10] = '{1, 10'd7, 1, 0, 10'd8,  4'h0, 32'h0,         1, 0, 0, 1, 32'd24};
        vecs[11] = '{0, 10'd0, 0, 0, 10'd0,  4'h0, 32'h0,         0, 0, 1, 0, 32'd28};
        vecs[12] = '{0, 10'd0, 1, 0, 10'd9,  4'h0, 32'h0,         0, 1, 0, 0, 32'h0};
        vecs[13] = '{0, 10'd0, 1, 0, 10'd10, 4'h0, 32'h0,         0, 1, 0, 1, 32'd36};
        vecs[14] = '{0, 10'd0, 0, 0, 10'd0,  4'h0, 32'h0,         0, 0, 0, 1, 32'd40};

        @(posedge clk); #1;
        do_reset("reset");
        @(negedge clk);
        check("post-reset m_reset_req", m_reset_req, 0);
        check("post-reset m_chipselect", m_chipselect, 0);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].fr, vecs[i].fa, vecs[i].lr, vecs[i].lw, vecs[i].la, vecs[i].be, vecs[i].wd);
            @(negedge clk);
            check($sformatf("vec%0d f_gnt", i), f_gnt, vecs[i].e_fg);
            check($sformatf("vec%0d l_gnt", i), l_gnt, vecs[i].e_lg);
            check($sformatf("vec%0d m_chipselect", i), m_chipselect, vecs[i].e_fg | vecs[i].e_lg);
            check($sformatf("vec%0d m_write", i), m_write, vecs[i].e_lg & vecs[i].lw);
            check($sformatf("vec%0d m_debugaccess", i), m_debugaccess, vecs[i].e_lg & vecs[i].lw);
            check($sformatf("vec%0d f_rvalid", i), f_rvalid, vecs[i].e_frv);
            check($sformatf("vec%0d l_rvalid", i), l_rvalid, vecs[i].e_lrv);
            if (vecs[i].e_frv) check($sformatf("vec%0d f_rdata", i), f_rdata, vecs[i].e_rd);
            if (vecs[i].e_lrv) check($sformatf("vec%0d l_rdata", i), l_rdata, vecs[i].e_rd);
            tick();
        end

        // Continuous contention from reset: F, L, F, L ... and four fetch stall cycles.
        do_reset("reset2");
        for (int k = 0; k < 8; k++) begin
            drive(1, 10'd1, 1, 0, 10'd2, 4'h0, 32'h0);
            @(negedge clk);
            check($sformatf("rr%0d f_gnt", k), f_gnt, (k % 2) == 0);
            check($sformatf("rr%0d l_gnt", k), l_gnt, (k % 2) == 1);
            if (k > 0) check($sformatf("rr%0d f_rvalid", k), f_rvalid, (k % 2) == 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
`ifdef IMEM_ARB_STALL_CNT_EN
        check("rr f_stall_cnt", f_stall_cnt, 4);
`endif
        tick();

        // Same-address collision with fetch as last owner: loader write first, fetch sees new data.
        drive(1, 10'd0, 0, 0, 10'd0, 4'h0, 32'h0);
        @(negedge clk);
        check("col pre f_gnt", f_gnt, 1);
        tick();
        drive(1, 10'h20, 1, 1, 10'h20, 4'hF, 32'hA5A51234);
        @(negedge clk);
        check("col l_gnt", l_gnt, 1);
        check("col f_gnt", f_gnt, 0);
        check("col m_debugaccess", m_debugaccess, 1);
        check("col m_address", m_address, 32'h20);
        tick();
        drive(1, 10'h20, 0, 0, 10'h0, 4'h0, 32'h0);
        @(negedge clk);
        check("col2 f_gnt", f_gnt, 1);
        check("col2 l_rvalid", l_rvalid, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("col3 f_rvalid", f_rvalid, 1);
        check("col3 f_rdata", f_rdata, 32'hA5A51234);
        tick();

        // Reset right after a loader grant: in-flight rvalid dropped, fetch wins the first conflict.
        drive(0, 10'd0, 1, 0, 10'd3, 4'h0, 32'h0);
        @(negedge clk);
        check("mid l_gnt", l_gnt, 1);
        tick();
        drive(1, 10'd1, 0, 0, 10'd0, 4'h0, 32'h0);
        @(negedge clk);
        check("mid f_gnt", f_gnt, 1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("mid f_rvalid in reset", f_rvalid, 0);
        check("mid m_reset_req", m_reset_req, 1);
        tick();
        @(negedge clk);
        check("mid f_rvalid held", f_rvalid, 0);
        tick();
        reset_n = 1'b1;
        drive(1, 10'd4, 1, 0, 10'd5, 4'h0, 32'h0);
        @(negedge clk);
        check("mid rel f_gnt", f_gnt, 1);
        check("mid rel l_gnt", l_gnt, 0);
        check("mid rel f_rvalid", f_rvalid, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);

        // Randomized phase in a region untouched so far, against the reference model.
        do_reset("reset3");
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        prefer_fetch = 1'b1;
        begin
            bit            fp = 0, lp = 0, lwe = 0;
            int            fa = 0, la = 0;
            logic [BW-1:0] lbe = '0;
            logic [DW-1:0] lwd = '0;
            bit            pf_v = 0, pl_v = 0;
            logic [DW-1:0] pf_d = '0, pl_d = '0;
            bit            efg, elg;
            for (int c = 0; c < 400; c++) begin
                if (!fp && $urandom_range(0, 2) != 0) begin
                    fp = 1; fa = $urandom_range(0, 31);
                end
                if (!lp && $urandom_range(0, 2) != 0) begin
                    lp = 1; la = $urandom_range(0, 31); lwe = $urandom_range(0, 1);
                    lbe = BW'($urandom_range(0, 15)); lwd = $urandom;
                end
                drive(fp, AW'(10'h100 + fa), lp, lwe, AW'(10'h100 + la), lbe, lwd);
                @(negedge clk);
                efg = fp && (!lp || prefer_fetch);
                elg = lp && (!fp || !prefer_fetch);
                check("rnd f_gnt", f_gnt, efg);
                check("rnd l_gnt", l_gnt, elg);
                check("rnd m_chipselect", m_chipselect, efg | elg);
                check("rnd m_write", m_write, elg && lwe);
                check("rnd m_debugaccess", m_debugaccess, elg && lwe);
                if (efg) check("rnd f m_address", m_address, 32'h100 + fa);
                if (elg) check("rnd l m_address", m_address, 32'h100 + la);
                if (elg && lwe) begin
                    check("rnd m_byteenable wr", m_byteenable, lbe);
                    check("rnd m_writedata", m_writedata, lwd);
                end else if (efg || elg) begin
                    check("rnd m_byteenable rd", m_byteenable, 4'hF);
                end
                check("rnd f_rvalid", f_rvalid, pf_v);
                check("rnd l_rvalid", l_rvalid, pl_v);
                if (pf_v) check("rnd f_rdata", f_rdata, pf_d);
                if (pl_v) check("rnd l_rdata", l_rdata, pl_d);
                pf_v = efg;
                pf_d = ref_mem[fa];
                pl_v = elg && !lwe;
                pl_d = ref_mem[la];
                if (elg && lwe)
                    for (int b = 0; b < BW; b++)
                        if (lbe[b]) ref_mem[la][b*8 +: 8] = lwd[b*8 +: 8];
                if (efg) begin fp = 0; prefer_fetch = 1'b0; end
                if (elg) begin lp = 0; prefer_fetch = 1'b1; end
                tick();
            end
        end

        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_imem_arbiter

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter sharing the single-port 1024x32 instruction blockram between the core's instruction-fetch port and the debug loader port. The loader can read and write. The fetch port can only read. The block issues at most one memory access per cycle, chosen by round-robin when both ports request. It returns read data with a per-port valid one cycle after the grant.

## Interface
- `ADDR_W`, default 10: word address width; must match the RAM depth (1024 words).
- `DATA_W`, default 32: data width; byteenable width is DATA_W/8.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `f_req`  in  1  fetch read request.
- `f_addr`  in  ADDR_W  fetch word address.
- `f_gnt`  out  1  fetch request accepted this cycle.
- `f_rvalid`  out  1  `f_rdata` is valid.
- `f_rdata`  out  DATA_W  fetch read data.
- `l_req`  in  1  loader request.
- `l_we`  in  1  1 = write, 0 = read.
- `l_addr`  in  ADDR_W  loader word address.
- `l_be`  in  DATA_W/8  loader byte enables; ignored on reads.
- `l_wdata`  in  DATA_W  loader write data.
- `l_gnt`  out  1  loader request accepted this cycle.
- `l_rvalid`  out  1  `l_rdata` is valid; reads only.
- `l_rdata`  out  DATA_W  loader read data.
- `m_address`  out  ADDR_W  RAM address.
- `m_byteenable`  out  DATA_W/8  RAM byte enables; all ones on reads.
- `m_chipselect`  out  1  RAM access this cycle.
- `m_write`  out  1  RAM write strobe.
- `m_debugaccess`  out  1  asserted with every loader write; the RAM gates writes on it.
- `m_writedata`  out  DATA_W  RAM write data.
- `m_clken`  out  1  constant 1.
- `m_reset_req`  out  1  equals `~reset_n`.
- `m_readdata`  in  DATA_W  RAM q; valid the cycle after the access.
- `f_stall_cnt`  out  32  present only with `IMEM_ARB_STALL_CNT_EN`.

## Operation
- A request is accepted in a cycle when both `req` and `gnt` are high at the rising edge.
- A requester must hold `req`, `addr`, `we`, `be` and `wdata` stable until it sees `gnt`.
- Grant logic is combinational from the `req` inputs and the registered `last_owner` bit (0 = fetch, 1 = loader).
  - Only one port requesting: that port is granted.
  - Both requesting: the port that is not `last_owner` is granted.
  - Neither requesting: no grant; `m_chipselect` is 0.
- `last_owner` is updated only on a granted cycle.
- Memory-side outputs are driven combinationally from the granted port in the same cycle.
  - `m_write = l_gnt & l_we`.
  - `m_debugaccess = l_gnt & l_we`.
- Read-return pipeline: a 2-bit register `rd_owner` records {fetch-read, loader-read} for the access granted in the previous cycle.
  - `f_rvalid = rd_owner[0]` and `l_rvalid = rd_owner[1]`.
  - `f_rdata` and `l_rdata` both carry `m_readdata`; they are meaningful only while the matching `rvalid` is high.
- Loader writes produce no `rvalid`.
- A loader write followed by a read of the same address returns the new data, because accesses are serialised.

## Timing
- Read latency is 1 cycle: a grant at edge N gives `rvalid` high for exactly the cycle after edge N.
- Throughput is one access per cycle. Each port gets at least every other cycle under contention.
- Reset values, held while `reset_n` is low:
  - `f_gnt`, `l_gnt`, `f_rvalid`, `l_rvalid`, `m_chipselect`, `m_write` and `m_debugaccess` are 0.
  - `last_owner` = 1, so fetch wins the first conflict.
  - `rd_owner` = 0.
  - `f_stall_cnt` = 0.
  - `m_reset_req` = 1.
- Grants are forced to 0 while `reset_n` is low.
- Reset mid-operation: an in-flight read's `rvalid` is dropped. The next cycle after reset is clean.
- Dropping `req` before `gnt` is legal; no access is issued.
- Back-to-back grants to the same port are allowed when the other port is idle.

## Configuration
- `IMEM_ARB_STALL_CNT_EN` defined:
  - `f_stall_cnt` is present.
  - It increments on every cycle with `f_req & ~f_gnt` while `reset_n` is high.
  - It saturates at 0xFFFF_FFFF.
- `IMEM_ARB_STALL_CNT_EN` undefined: the port and its logic are absent; arbitration is unchanged.

## Structure
- Shared package `imem_pkg`:
  - `IMEM_ADDR_W` = 10 and `IMEM_DATA_W` = 32.
  - Owner enum `imem_owner_e` {OWN_FETCH = 0, OWN_LOADER = 1}.
- One natural sub-module, `rr_arb2`: a 2-requester round-robin grant generator with a `last_owner` register.
- The read-return pipeline and memory muxing stay in the top module.

## Test plan
- Reset then idle → all grants, valids and `m_chipselect` are 0; `m_reset_req` is 1 during reset and 0 after.
- Fetch only, addresses 0..3 on consecutive cycles, RAM preloaded with word = address × 4 → `f_gnt` on 4 cycles; `f_rvalid` on 4 cycles, one cycle later; `f_rdata` = 0, 4, 8, 12.
- Loader writes 0xDEADBEEF to 0x3FF with `be` = 4'b0011, then reads 0x3FF (RAM previously 0) → `l_rdata` = 0x0000BEEF one cycle after the read grant.
- Both ports request continuously for 8 cycles after reset → grants alternate F, L, F, L…; with the macro defined, `f_stall_cnt` = 4.
- Loader write and fetch read to the same address in the same cycle, with `last_owner` = fetch → loader granted first; the fetch read, granted the next cycle, returns the written data.
- Reset asserted the cycle after a fetch grant → `f_rvalid` stays 0; after release, the first conflict grants fetch.
